// File: rtl/line_option_filter.sv
// line_option_filter: nonogram solver stage that filters one line's candidate
// options against its known cells, re-enqueues the survivors and folds them
// (AND/OR) into newly determined cells.
// Optional feature macro: LINE_FILTER_CONFLICT_EN (registers a zero-survivor
// conflict flag; when undefined, conflict is tied low).
module line_option_filter #(
  parameter int LINE_W = 5,
  parameter int CNT_W  = 7,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  line_ind,
  input  logic [LINE_W-1:0] known_in,
  input  logic [LINE_W-1:0] val_in,
  input  logic [CNT_W-1:0]  option_num,
  input  logic              opt_valid,
  input  logic [LINE_W-1:0] opt_data,
  output logic              opt_ready,
  output logic              put_back_valid,
  output logic [LINE_W-1:0] put_back_data,
  input  logic              put_back_ready,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  line_ind_out,
  output logic [CNT_W-1:0]  new_option_num,
  output logic [LINE_W-1:0] known_out,
  output logic [LINE_W-1:0] val_out,
  output logic              changed,
  output logic              conflict
);

  typedef enum logic [1:0] {IDLE, FILTER, COMMIT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [IDX_W-1:0]  line_reg;
  logic [LINE_W-1:0] known_reg;
  logic [LINE_W-1:0] val_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [CNT_W-1:0]  survivors_reg;
  logic [LINE_W-1:0] and_acc_reg;
  logic [LINE_W-1:0] or_acc_reg;

  logic              done_reg;
  logic [IDX_W-1:0]  line_out_reg;
  logic [CNT_W-1:0]  num_out_reg;
  logic [LINE_W-1:0] known_out_reg;
  logic [LINE_W-1:0] val_out_reg;
  logic              changed_reg;

  logic              in_filter;
  logic              consistent;
  logic              take;
  logic              has_survivor;
  logic [LINE_W-1:0] commit_known;
  logic [LINE_W-1:0] commit_val;

  // Option check and FIFO handshakes: pure pass-through, valid never waits on ready.
  always_comb begin
    in_filter      = (state == FILTER);
    consistent     = (((opt_data ^ val_reg) & known_reg) == '0);
    opt_ready      = in_filter & (put_back_ready | ~consistent);
    put_back_valid = in_filter & opt_valid & consistent;
    put_back_data  = in_filter ? opt_data : '0;
    take           = opt_valid & opt_ready;
    busy           = (state != IDLE);
  end

  // Fold survivors into the line: cells that are 1 in every survivor or 0 in
  // every survivor become known; with no survivors the line is left untouched.
  always_comb begin
    has_survivor = (survivors_reg != '0);
    commit_known = known_reg;
    commit_val   = val_reg;
    if (has_survivor) begin
      commit_known = known_reg | and_acc_reg | ~or_acc_reg;
      commit_val   = (val_reg & known_reg) | and_acc_reg;
    end
  end

  // Job sequencing, option accumulation and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      line_reg      <= '0;
      known_reg     <= '0;
      val_reg       <= '0;
      remaining_reg <= '0;
      survivors_reg <= '0;
      and_acc_reg   <= '0;
      or_acc_reg    <= '0;
      done_reg      <= 1'b0;
      line_out_reg  <= '0;
      num_out_reg   <= '0;
      known_out_reg <= '0;
      val_out_reg   <= '0;
      changed_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            line_reg      <= line_ind;
            known_reg     <= known_in;
            val_reg       <= val_in;
            remaining_reg <= option_num;
            survivors_reg <= '0;
            and_acc_reg   <= '1;
            or_acc_reg    <= '0;
            state         <= (option_num == '0) ? COMMIT : FILTER;
          end
        end
        FILTER: begin
          if (take) begin
            remaining_reg <= remaining_reg - CNT_W'(1);
            if (consistent) begin
              if (survivors_reg != CNT_MAX)
                survivors_reg <= survivors_reg + CNT_W'(1);
              and_acc_reg <= and_acc_reg & opt_data;
              or_acc_reg  <= or_acc_reg | opt_data;
            end
            if (remaining_reg == CNT_W'(1))
              state <= COMMIT;
          end
        end
        COMMIT: begin
          line_out_reg  <= line_reg;
          num_out_reg   <= survivors_reg;
          known_out_reg <= commit_known;
          val_out_reg   <= commit_val;
          changed_reg   <= (commit_known != known_reg);
          done_reg      <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          done_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_FILTER_CONFLICT_EN
  logic conflict_reg;

  // Zero-survivor flag, captured alongside the other results.
  always_ff @(posedge clk) begin
    if (rst)
      conflict_reg <= 1'b0;
    else if (state == COMMIT)
      conflict_reg <= ~has_survivor;
  end

  assign conflict = conflict_reg;
`else
  assign conflict = 1'b0;
`endif

  assign done           = done_reg;
  assign line_ind_out   = line_out_reg;
  assign new_option_num = num_out_reg;
  assign known_out      = known_out_reg;
  assign val_out        = val_out_reg;
  assign changed        = changed_reg;

endmodule

// File: tb/tb_line_option_filter.sv
// Directed, scoreboard-based bench for line_option_filter (LINE_W=5).
// Expected put-backs and job results are queued when stimulus is driven and
// checked when the DUT presents them.
module tb_line_option_filter;

  localparam int LINE_W = 5;
  localparam int CNT_W  = 7;
  localparam int IDX_W  = 5;
`ifdef LINE_FILTER_CONFLICT_EN
  localparam logic CF_EN = 1'b1;
`else
  localparam logic CF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] k;
    logic [LINE_W-1:0] v;
    logic [CNT_W-1:0]  n;
    logic              ch;
    logic              cf;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IDX_W-1:0]  line_ind;
  logic [LINE_W-1:0] known_in;
  logic [LINE_W-1:0] val_in;
  logic [CNT_W-1:0]  option_num;
  logic              opt_valid;
  logic [LINE_W-1:0] opt_data;
  logic              opt_ready;
  logic              put_back_valid;
  logic [LINE_W-1:0] put_back_data;
  logic              put_back_ready;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  line_ind_out;
  logic [CNT_W-1:0]  new_option_num;
  logic [LINE_W-1:0] known_out;
  logic [LINE_W-1:0] val_out;
  logic              changed;
  logic              conflict;

  int n_checks = 0;
  int n_fail   = 0;

  logic [LINE_W-1:0] pb_q[$];
  res_t              res_q[$];

  line_option_filter #(.LINE_W(LINE_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .line_ind(line_ind),
    .known_in(known_in), .val_in(val_in), .option_num(option_num),
    .opt_valid(opt_valid), .opt_data(opt_data), .opt_ready(opt_ready),
    .put_back_valid(put_back_valid), .put_back_data(put_back_data),
    .put_back_ready(put_back_ready), .busy(busy), .done(done),
    .line_ind_out(line_ind_out), .new_option_num(new_option_num),
    .known_out(known_out), .val_out(val_out), .changed(changed),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed unexpected event, expected none", tag);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (put_back_valid && put_back_ready) begin
        if (pb_q.size() == 0) fail_now("pb_unexpected");
        else check("pb_data", 32'(put_back_data), 32'(pb_q.pop_front()));
      end
      if (done) begin
        if (res_q.size() == 0) fail_now("done_unexpected");
        else begin
          res_t e;
          e = res_q.pop_front();
          $display("job line %0d: known_out=%b val_out=%b num=%0d changed=%0b conflict=%0b",
                   line_ind_out, known_out, val_out, new_option_num, changed, conflict);
          check("line_ind_out",   32'(line_ind_out),   32'(e.idx));
          check("known_out",      32'(known_out),      32'(e.k));
          check("val_out",        32'(val_out),        32'(e.v));
          check("new_option_num", 32'(new_option_num), 32'(e.n));
          check("changed",        32'(changed),        32'(e.ch));
          check("conflict",       32'(conflict),       32'(e.cf));
        end
      end
    end
  end

  task automatic start_job(input logic [IDX_W-1:0] idx, input logic [LINE_W-1:0] k,
                           input logic [LINE_W-1:0] v, input logic [CNT_W-1:0] n,
                           input bit push, input res_t exp);
    if (push) res_q.push_back(exp);
    start = 1'b1; line_ind = idx; known_in = k; val_in = v; option_num = n;
    @(posedge clk); #1;
    start = 1'b0; line_ind = '0; known_in = '0; val_in = '0; option_num = '0;
  endtask

  // Present one option; keep=expected consistent; hold=cycles of put_back_ready=0.
  task automatic offer(input logic [LINE_W-1:0] d, input bit keep, input int hold);
    opt_valid = 1'b1;
    opt_data  = d;
    put_back_ready = keep ? (hold == 0) : 1'b0;
    if (keep) pb_q.push_back(d);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_opt_ready", 32'(opt_ready), 32'd0);
      check("bp_pb_valid", 32'(put_back_valid), 32'd1);
      @(posedge clk); #1;
    end
    if (keep) put_back_ready = 1'b1;
    @(negedge clk);
    check("opt_ready", 32'(opt_ready), 32'd1);
    check("pb_valid", 32'(put_back_valid), 32'(keep));
    @(posedge clk); #1;
    opt_valid = 1'b0; opt_data = '0; put_back_ready = 1'b1;
  endtask

  // done must appear exactly two cycles after the last handshake / empty start.
  task automatic finish_job();
    @(negedge clk);
    check("commit_done_low", 32'(done), 32'd0);
    check("commit_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("pb_queue_empty", 32'(pb_q.size()), 32'd0);
    check("res_queue_empty", 32'(res_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; line_ind = '0; known_in = '0; val_in = '0;
    option_num = '0; opt_valid = 1'b0; opt_data = '0; put_back_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_known_out", 32'(known_out), 32'd0);
    check("rst_num", 32'(new_option_num), 32'd0);
    check("rst_opt_ready", 32'(opt_ready), 32'd0);
    @(posedge clk); #1;

    // Single option fully assigns the line.
    start_job(5'd3, 5'b00000, 5'b00000, 7'd1, 1, '{5'd3, 5'b11111, 5'b10101, 7'd1, 1'b1, 1'b0});
    offer(5'b10101, 1, 0);
    finish_job();

    // Overlap of three options; start while busy must be ignored.
    start_job(5'd7, 5'b00000, 5'b00000, 7'd3, 1, '{5'd7, 5'b00100, 5'b00100, 7'd3, 1'b1, 1'b0});
    offer(5'b11100, 1, 0);
    start = 1'b1; line_ind = 5'd31; known_in = 5'b11111; option_num = 7'd1;
    @(negedge clk);
    check("busy_during_job", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; line_ind = '0; known_in = '0; option_num = '0;
    offer(5'b01110, 1, 0);
    offer(5'b00111, 1, 0);
    finish_job();

    // Filtering with backpressure on a survivor; dropped option ignores ready.
    start_job(5'd12, 5'b10000, 5'b00000, 7'd3, 1, '{5'd12, 5'b10110, 5'b00110, 7'd2, 1'b1, 1'b0});
    offer(5'b11100, 0, 0);
    offer(5'b01110, 1, 3);
    offer(5'b00111, 1, 0);
    finish_job();

    // Conflict: every option contradicts the known cells.
    start_job(5'd4, 5'b11111, 5'b00000, 7'd1, 1, '{5'd4, 5'b11111, 5'b00000, 7'd0, 1'b0, CF_EN});
    offer(5'b10101, 0, 0);
    finish_job();

    // Zero options: done two cycles after start.
    start_job(5'd9, 5'b00011, 5'b00001, 7'd0, 1, '{5'd9, 5'b00011, 5'b00001, 7'd0, 1'b0, CF_EN});
    finish_job();

    // Reset in the middle of FILTER drops the job.
    start_job(5'd17, 5'b00000, 5'b00000, 7'd3, 0, '0);
    offer(5'b11000, 1, 0);
    opt_valid = 1'b1; opt_data = 5'b01100;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_opt_ready", 32'(opt_ready), 32'd0);
    check("midrst_pb_valid", 32'(put_back_valid), 32'd0);
    check("midrst_known_out", 32'(known_out), 32'd0);
    check("midrst_line_out", 32'(line_ind_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; opt_valid = 1'b0; opt_data = '0;

    // New job after reset completes normally.
    start_job(5'd21, 5'b00001, 5'b00001, 7'd2, 1, '{5'd21, 5'b11111, 5'b10101, 7'd1, 1'b1, 1'b0});
    offer(5'b10101, 1, 0);
    offer(5'b00100, 0, 0);
    finish_job();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
